// File: rtl/rv_pkg.sv
// Shared RISC-V pipeline types: writeback source select, load size and
// writeback-stage FSM states.
package rv_pkg;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC4 = 2'd2
   } t_wb_sel;

   typedef enum logic [1:0] {
      MEM_B = 2'd0,
      MEM_H = 2'd1,
      MEM_W = 2'd2
   } t_mem_size;

   typedef enum logic {
      RUN       = 1'b0,
      WAIT_LOAD = 1'b1
   } t_wb_state;

endpackage

// File: rtl/rv_load_align.sv
// Extracts a byte/half/word from an aligned 32-bit memory word and sign- or
// zero-extends it. Purely combinational; shared with the LSU.
module rv_load_align
   import rv_pkg::*;
(
   input  logic [31:0] data,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (off)
         2'd0:    byte_sel = data[7:0];
         2'd1:    byte_sel = data[15:8];
         2'd2:    byte_sel = data[23:16];
         default: byte_sel = data[31:24];
      endcase
      // off[0] is ignored for halves; misalignment is not trapped here
      half_sel = off[1] ? data[31:16] : data[15:0];

      case (t_mem_size'(size))
         MEM_B:   result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
         MEM_H:   result = {{16{~is_unsigned & half_sel[15]}}, half_sel};
         default: result = data;
      endcase
   end

endmodule

// File: rtl/rv_wb_stage.sv
// Memory-response / writeback stage (Q103 -> Q104): selects writeback data,
// stalls upstream while a load waits on dmem, and drops loads that time out.
//
// state     | meaning
// ----------+------------------------------------------------------------
// RUN       | normal flow; one instruction per cycle, stall only on a load
//           | whose response is not present this cycle
// WAIT_LOAD | load held in Q103, waiting for dmem_rsp_valid or timeout
module rv_wb_stage
   import rv_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int LOAD_TIMEOUT = 16
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_Q103H,
   output logic            ready_Q103H,
   input  logic            reg_write_en_Q103H,
   input  logic [4:0]      reg_dst_Q103H,
   input  logic [1:0]      sel_wb_Q103H,
   input  logic [XLEN-1:0] alu_result_Q103H,
   input  logic [XLEN-1:0] pc_Q103H,
   input  logic [1:0]      mem_size_Q103H,
   input  logic            mem_unsigned_Q103H,
   input  logic            dmem_rsp_valid,
   input  logic [XLEN-1:0] dmem_rsp_data,
   output logic [XLEN-1:0] wb_data_Q104H,
   output logic [4:0]      reg_dst_Q104H,
   output logic            reg_write_en_Q104H,
   output logic            load_timeout_err
);

   localparam int CW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT - 1);

   t_wb_state      state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           is_load;
   logic           drop;
   logic           we_d;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] wb_data_d;

   assign is_load = valid_Q103H && (t_wb_sel'(sel_wb_Q103H) == WB_MEM);

   rv_load_align u_align (
      .data        (dmem_rsp_data),
      .off         (alu_result_Q103H[1:0]),
      .size        (mem_size_Q103H),
      .is_unsigned (mem_unsigned_Q103H),
      .result      (load_data)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ready_Q103H = 1'b1;
      drop        = 1'b0;
      case (state_q)
         RUN: begin
            if (is_load && !dmem_rsp_valid) begin
               ready_Q103H = 1'b0;
               state_d     = WAIT_LOAD;
               cnt_d       = '0;
            end
         end
         WAIT_LOAD: begin
            ready_Q103H = dmem_rsp_valid || (cnt_q == CNT_LAST);
            if (dmem_rsp_valid) begin
               state_d = RUN;
            end else if (cnt_q == CNT_LAST) begin
               // consume the load without writing it
               state_d = RUN;
               drop    = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      case (t_wb_sel'(sel_wb_Q103H))
         WB_MEM:  wb_data_d = load_data;
         WB_PC4:  wb_data_d = pc_Q103H + XLEN'(4);
         default: wb_data_d = alu_result_Q103H;
      endcase
      we_d = valid_Q103H && ready_Q103H && reg_write_en_Q103H &&
             (reg_dst_Q103H != 5'd0) && !drop;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q            <= RUN;
         cnt_q              <= '0;
         wb_data_Q104H      <= '0;
         reg_dst_Q104H      <= '0;
         reg_write_en_Q104H <= 1'b0;
         load_timeout_err   <= 1'b0;
      end else begin
         state_q            <= state_d;
         cnt_q              <= cnt_d;
         wb_data_Q104H      <= wb_data_d;
         reg_dst_Q104H      <= reg_dst_Q103H;
         reg_write_en_Q104H <= we_d;
         if (drop)
            load_timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rv_wb_stage.sv
// Directed bench for rv_wb_stage: ALU/PC4 writes, load alignment, delayed
// loads, timeout drop and reset during a wait.
module tb_rv_wb_stage;
   import rv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_Q103H;
   logic        ready_Q103H;
   logic        reg_write_en_Q103H;
   logic [4:0]  reg_dst_Q103H;
   logic [1:0]  sel_wb_Q103H;
   logic [31:0] alu_result_Q103H;
   logic [31:0] pc_Q103H;
   logic [1:0]  mem_size_Q103H;
   logic        mem_unsigned_Q103H;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rsp_data;
   logic [31:0] wb_data_Q104H;
   logic [4:0]  reg_dst_Q104H;
   logic        reg_write_en_Q104H;
   logic        load_timeout_err;

   int checks = 0;
   int errors = 0;

   rv_wb_stage #(.XLEN(32), .LOAD_TIMEOUT(4)) dut (
      .clk                (clk),
      .rst                (rst),
      .valid_Q103H        (valid_Q103H),
      .ready_Q103H        (ready_Q103H),
      .reg_write_en_Q103H (reg_write_en_Q103H),
      .reg_dst_Q103H      (reg_dst_Q103H),
      .sel_wb_Q103H       (sel_wb_Q103H),
      .alu_result_Q103H   (alu_result_Q103H),
      .pc_Q103H           (pc_Q103H),
      .mem_size_Q103H     (mem_size_Q103H),
      .mem_unsigned_Q103H (mem_unsigned_Q103H),
      .dmem_rsp_valid     (dmem_rsp_valid),
      .dmem_rsp_data      (dmem_rsp_data),
      .wb_data_Q104H      (wb_data_Q104H),
      .reg_dst_Q104H      (reg_dst_Q104H),
      .reg_write_en_Q104H (reg_write_en_Q104H),
      .load_timeout_err   (load_timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // inputs change and outputs are sampled 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic v, input logic we, input logic [4:0] rd,
                        input t_wb_sel sel, input logic [31:0] alu,
                        input logic [31:0] pc, input t_mem_size sz, input logic uns);
      valid_Q103H        = v;
      reg_write_en_Q103H = we;
      reg_dst_Q103H      = rd;
      sel_wb_Q103H       = sel;
      alu_result_Q103H   = alu;
      pc_Q103H           = pc;
      mem_size_Q103H     = sz;
      mem_unsigned_Q103H = uns;
   endtask

   task automatic expect_wb(input string tag, input logic we, input logic [4:0] rd,
                            input logic [31:0] data);
      chk({tag, ".we"}, {31'b0, reg_write_en_Q104H}, {31'b0, we});
      if (we) begin
         chk({tag, ".dst"},  {27'b0, reg_dst_Q104H}, {27'b0, rd});
         chk({tag, ".data"}, wb_data_Q104H, data);
      end
   endtask

   // single-cycle instruction: ready must be high, write lands next cycle
   task automatic one_shot(input string tag, input logic we, input logic [4:0] rd,
                           input t_wb_sel sel, input logic [31:0] alu,
                           input logic [31:0] pc, input t_mem_size sz, input logic uns,
                           input logic rsp, input logic [31:0] rdata,
                           input logic exp_we, input logic [31:0] exp_data);
      issue(1'b1, we, rd, sel, alu, pc, sz, uns);
      dmem_rsp_valid = rsp;
      dmem_rsp_data  = rdata;
      #1;
      chk({tag, ".ready"}, {31'b0, ready_Q103H}, 32'd1);
      step();
      expect_wb(tag, exp_we, rd, exp_data);
      issue(1'b0, 1'b0, 5'd0, WB_ALU, 32'd0, 32'd0, MEM_W, 1'b0);
      dmem_rsp_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      issue(1'b0, 1'b0, 5'd0, WB_ALU, 32'd0, 32'd0, MEM_W, 1'b0);
      dmem_rsp_valid = 1'b0;
      dmem_rsp_data  = 32'd0;
      step();
      step();
      rst = 1'b0;
      chk("rst.we",   {31'b0, reg_write_en_Q104H}, 32'd0);
      chk("rst.dst",  {27'b0, reg_dst_Q104H}, 32'd0);
      chk("rst.data", wb_data_Q104H, 32'd0);
      chk("rst.err",  {31'b0, load_timeout_err}, 32'd0);
      chk("rst.ready", {31'b0, ready_Q103H}, 32'd1);

      one_shot("alu",  1, 5'd5, WB_ALU, 32'hDEAD_BEEF, 32'h0, MEM_W, 0, 0, 32'h0, 1, 32'hDEAD_BEEF);
      one_shot("x0",   1, 5'd0, WB_ALU, 32'h1111_2222, 32'h0, MEM_W, 0, 0, 32'h0, 0, 32'h0);
      one_shot("pc4",  1, 5'd1, WB_PC4, 32'h0, 32'hFFFF_FFFC, MEM_W, 0, 0, 32'h0, 1, 32'h0000_0000);
      one_shot("nowe", 0, 5'd4, WB_ALU, 32'h5, 32'h0, MEM_W, 0, 0, 32'h0, 0, 32'h0);
      // stray response in RUN with a non-load must not stall
      one_shot("alu_rsp", 1, 5'd6, WB_ALU, 32'h0000_0042, 32'h0, MEM_W, 0, 1, 32'hFFFF_FFFF, 1, 32'h0000_0042);

      one_shot("lb",  1, 5'd2, WB_MEM, 32'h1003, 32'h0, MEM_B, 0, 1, 32'h80AA_BBCC, 1, 32'hFFFF_FF80);
      one_shot("lbu", 1, 5'd2, WB_MEM, 32'h1003, 32'h0, MEM_B, 1, 1, 32'h80AA_BBCC, 1, 32'h0000_0080);
      one_shot("lb1", 1, 5'd2, WB_MEM, 32'h1001, 32'h0, MEM_B, 0, 1, 32'h80AA_BBCC, 1, 32'hFFFF_FFBB);
      one_shot("lh",  1, 5'd3, WB_MEM, 32'h1002, 32'h0, MEM_H, 0, 1, 32'h80AA_BBCC, 1, 32'hFFFF_80AA);
      one_shot("lhu", 1, 5'd3, WB_MEM, 32'h1002, 32'h0, MEM_H, 1, 1, 32'h80AA_BBCC, 1, 32'h0000_80AA);
      one_shot("lh0", 1, 5'd3, WB_MEM, 32'h1001, 32'h0, MEM_H, 0, 1, 32'h80AA_BBCC, 1, 32'hFFFF_BBCC);
      one_shot("lw",  1, 5'd8, WB_MEM, 32'h1003, 32'h0, MEM_W, 0, 1, 32'h80AA_BBCC, 1, 32'h80AA_BBCC);

      // delayed load: response 3 cycles after valid
      issue(1'b1, 1'b1, 5'd7, WB_MEM, 32'h2000, 32'h0, MEM_W, 1'b0);
      dmem_rsp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("dly.ready%0d", i), {31'b0, ready_Q103H}, 32'd0);
         step();
         chk($sformatf("dly.we%0d", i), {31'b0, reg_write_en_Q104H}, 32'd0);
      end
      dmem_rsp_valid = 1'b1;
      dmem_rsp_data  = 32'h1234_5678;
      #1;
      chk("dly.ready_rsp", {31'b0, ready_Q103H}, 32'd1);
      step();
      expect_wb("dly", 1'b1, 5'd7, 32'h1234_5678);
      issue(1'b0, 1'b0, 5'd0, WB_ALU, 32'd0, 32'd0, MEM_W, 1'b0);
      dmem_rsp_valid = 1'b0;

      // response on the final wait cycle wins over the timeout
      issue(1'b1, 1'b1, 5'd10, WB_MEM, 32'h3001, 32'h0, MEM_B, 1'b1);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("race.ready%0d", i), {31'b0, ready_Q103H}, 32'd0);
         step();
      end
      dmem_rsp_valid = 1'b1;
      dmem_rsp_data  = 32'h0000_9A00;
      #1;
      chk("race.ready_last", {31'b0, ready_Q103H}, 32'd1);
      step();
      expect_wb("race", 1'b1, 5'd10, 32'h0000_009A);
      chk("race.err", {31'b0, load_timeout_err}, 32'd0);
      issue(1'b0, 1'b0, 5'd0, WB_ALU, 32'd0, 32'd0, MEM_W, 1'b0);
      dmem_rsp_valid = 1'b0;

      // timeout: stall cycle + 3 waiting cycles, then consumed on the 4th
      issue(1'b1, 1'b1, 5'd9, WB_MEM, 32'h4000, 32'h0, MEM_W, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("to.ready%0d", i), {31'b0, ready_Q103H}, 32'd0);
         step();
         chk($sformatf("to.we%0d", i), {31'b0, reg_write_en_Q104H}, 32'd0);
      end
      chk("to.err_before", {31'b0, load_timeout_err}, 32'd0);
      #1;
      chk("to.ready_last", {31'b0, ready_Q103H}, 32'd1);
      step();
      chk("to.we_drop", {31'b0, reg_write_en_Q104H}, 32'd0);
      chk("to.err", {31'b0, load_timeout_err}, 32'd1);
      issue(1'b0, 1'b0, 5'd0, WB_ALU, 32'd0, 32'd0, MEM_W, 1'b0);
      one_shot("to.alu", 1, 5'd3, WB_ALU, 32'h0000_0055, 32'h0, MEM_W, 0, 0, 32'h0, 1, 32'h0000_0055);
      chk("to.err_held", {31'b0, load_timeout_err}, 32'd1);

      // reset while waiting on a load
      issue(1'b1, 1'b1, 5'd11, WB_MEM, 32'h5000, 32'h0, MEM_W, 1'b0);
      step();
      step();
      #1;
      chk("rw.ready_wait", {31'b0, ready_Q103H}, 32'd0);
      rst = 1'b1;
      issue(1'b0, 1'b0, 5'd0, WB_ALU, 32'd0, 32'd0, MEM_W, 1'b0);
      step();
      rst = 1'b0;
      chk("rw.we",   {31'b0, reg_write_en_Q104H}, 32'd0);
      chk("rw.dst",  {27'b0, reg_dst_Q104H}, 32'd0);
      chk("rw.data", wb_data_Q104H, 32'd0);
      chk("rw.err",  {31'b0, load_timeout_err}, 32'd0);
      chk("rw.ready_run", {31'b0, ready_Q103H}, 32'd1);
      dmem_rsp_valid = 1'b1;
      dmem_rsp_data  = 32'hCAFE_F00D;
      step();
      chk("rw.late_rsp_we", {31'b0, reg_write_en_Q104H}, 32'd0);
      dmem_rsp_valid = 1'b0;
      one_shot("rw.alu", 1, 5'd12, WB_ALU, 32'h0BAD_CAFE, 32'h0, MEM_W, 0, 0, 32'h0, 1, 32'h0BAD_CAFE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
